mc_option_scheduler: RTL and testbench
======================================

// Module: mc_option_scheduler
// PURPOSE
//  Sequences the Monte Carlo pricing pipeline: queues incoming options (mu, s, sigma), launches the
//  ExpMu/ExpSigma precompute units, and starts all MC cores when a precomputed bank is ready and the cores are idle.
//  Owns the ping-pong bank select and reports completion per option with an ID tag.
//  Replaces the SR_FF glue in the top level; sits between option input and calc_exp_*/MCCore instances.
// PARAMETERS
//  CORE_N      2   number of MC cores; all are started together, an option completes when all report done
//  QDEPTH      4   option queue depth (power of two)
//  LOG_QDEPTH  2   log2(QDEPTH)
//  ID_W        4   option ID width; IDs wrap modulo 2^ID_W
// PORTS
//  clk           in   1          clock, all logic on rising edge
//  rst           in   1          synchronous active-high reset
//  i_opt_valid   in   1          option offered this cycle
//  o_opt_ready   out  1          queue can accept (= not full, registered)
//  i_mu          in   18         0.18 fixed point
//  i_s           in   18         4.14 fixed point
//  i_sigma       in   18         0.18 fixed point
//  o_pre_start   out  1          one-cycle pulse to both precompute units
//  o_pre_mu      out  18         operands for current precompute, stable from pulse until next pulse
//  o_pre_s       out  18
//  o_pre_sigma   out  18
//  i_mu_done     in   1          ExpMu done pulse
//  i_sigma_done  in   1          ExpSigma done pulse
//  o_core_start  out  1          one-cycle pulse to all cores
//  o_switch      out  1          bank select to cores
//  i_core_done   in   CORE_N     per-core done pulses
//  o_res_valid   out  1          one-cycle pulse: option o_res_id fully priced
//  o_res_id      out  ID_W       ID of completed option
//  o_err         out  1          sticky: done pulse received while owning FSM not in RUN
// BEHAVIOUR
//  Reset: queue empty, o_opt_ready=1, all pulses 0, o_pre_*=0, o_switch=0, o_res_id=0, o_err=0, FSMs idle, ID counter 0.
//  Queue: accept on i_opt_valid&o_opt_ready; entry = {id, mu, s, sigma}; id counter increments per accept.
//   o_opt_ready is registered !full; when full and popping, ready rises the following cycle.
//  Pre FSM PRE_IDLE/PRE_RUN/PRE_HOLD:
//   IDLE & queue non-empty -> pop head, register operands+id, o_pre_start=1 next cycle, -> RUN.
//   Accept into empty queue at cycle 0 -> o_pre_start high in cycle 2.
//   RUN: latch mu_done, sigma_done separately (either order, or same cycle); both latched -> HOLD.
//   HOLD: wait for core launch; on launch -> IDLE (next pop may occur the following cycle).
//  Core FSM CORE_IDLE/CORE_RUN:
//   IDLE & pre HOLD -> o_core_start=1 next cycle, copy pre id to core id, clear done mask, -> RUN.
//   o_switch toggles on the edge ending the o_core_start cycle; cores read bank o_switch sampled during the start cycle,
//    precompute always writes bank ~o_switch.
//   RUN: OR i_core_done into sticky mask; mask all-ones -> o_res_valid=1 with o_res_id=core id next cycle, -> IDLE.
//   Core completion and new launch may overlap: precompute of option k+1 runs while cores price option k.
//  o_err: set on i_mu_done/i_sigma_done outside PRE_RUN, or i_core_done outside CORE_RUN; a repeated
//   done in RUN is not an error. Cleared only by rst.
//  rst mid-operation: discards queue and in-flight options; no o_res_valid for them; stray done pulses afterwards set o_err.
//  Throughput: one option per max(precompute time, core time) + 2 cycles.
// STRUCTURE
//  Shared package: FSM state encodings, fixed-point widths (18-bit operands), ID_W default.
//  Sub-module: mc_option_fifo (sync FIFO, WIDTH=ID_W+54, registered full/empty). FSMs and done mask are local.
// TESTING
//  Single option mu=0x00800,s=0x04000,sigma=0x01000 -> pre_start cycle 2 with same operands; mu_done@10, sigma_done@12
//   -> core_start cycle 14, o_switch 0->1 at 15; core_done {01}@30,{10}@34 -> o_res_valid cycle 35, id=0.
//  Five back-to-back offers, precompute stalled -> 4 accepted, o_opt_ready low in cycle after 4th; first pop -> ready rises next cycle.
//  Two options: 2nd pre_start issued one cycle after 1st core_start; 2nd core_start only after 1st o_res_valid; switch toggles twice.
//  mu_done and sigma_done same cycle; core_done both bits same cycle -> identical timing to staggered case, no o_err.
//  Core_done while CORE_IDLE -> o_err=1 and stays; rst mid-RUN -> all outputs at reset values next cycle, queue empty.
//  ID wrap: 17 options with ID_W=4 -> 17th result has o_res_id=0.

Source files
------------

// File: rtl/mc_option_scheduler_pkg.sv
// rtl/mc_option_scheduler_pkg.sv - shared types and widths for the MC option scheduler
package mc_option_scheduler_pkg;

  // Operand width for mu (0.18), s (4.14) and sigma (0.18)
  localparam int OPER_W   = 18;
  localparam int ID_W_DEF = 4;

  typedef enum logic [1:0] {
    PRE_IDLE = 2'd0,
    PRE_RUN  = 2'd1,
    PRE_HOLD = 2'd2
  } preState_t;

  typedef enum logic {
    CORE_IDLE = 1'b0,
    CORE_RUN  = 1'b1
  } coreState_t;

endpackage

// File: rtl/mc_option_fifo.sv
// rtl/mc_option_fifo.sv - synchronous option queue with registered full/empty flags
module mc_option_fifo #(
  parameter int WIDTH     = 58,
  parameter int DEPTH     = 4,
  parameter int LOG_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [LOG_DEPTH-1:0] wrPtr;
  logic [LOG_DEPTH-1:0] rdPtr;
  logic [LOG_DEPTH:0]   count;
  logic [LOG_DEPTH:0]   countNext;
  logic                 doPush;
  logic                 doPop;

  assign doPush  = push & ~full;
  assign doPop   = pop & ~empty;
  assign popData = mem[rdPtr];

  // Occupancy after this cycle's push/pop, used to register the flags
  always_comb begin
    countNext = count;
    if (doPush && !doPop) begin
      countNext = count + (LOG_DEPTH+1)'(1);
    end else if (!doPush && doPop) begin
      countNext = count - (LOG_DEPTH+1)'(1);
    end
  end

  // Pointers, occupancy and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (doPush) wrPtr <= wrPtr + LOG_DEPTH'(1);
      if (doPop)  rdPtr <= rdPtr + LOG_DEPTH'(1);
      count <= countNext;
      full  <= (countNext == (LOG_DEPTH+1)'(DEPTH));
      empty <= (countNext == '0);
    end
  end

  // Storage needs no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/mc_option_scheduler.sv
// rtl/mc_option_scheduler.sv - queues options, sequences precompute and MC cores, tags results
module mc_option_scheduler
  import mc_option_scheduler_pkg::*;
#(
  parameter int CORE_N     = 2,
  parameter int QDEPTH     = 4,
  parameter int LOG_QDEPTH = 2,
  parameter int ID_W       = ID_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_opt_valid,
  output logic              o_opt_ready,
  input  logic [OPER_W-1:0] i_mu,
  input  logic [OPER_W-1:0] i_s,
  input  logic [OPER_W-1:0] i_sigma,
  output logic              o_pre_start,
  output logic [OPER_W-1:0] o_pre_mu,
  output logic [OPER_W-1:0] o_pre_s,
  output logic [OPER_W-1:0] o_pre_sigma,
  input  logic              i_mu_done,
  input  logic              i_sigma_done,
  output logic              o_core_start,
  output logic              o_switch,
  input  logic [CORE_N-1:0] i_core_done,
  output logic              o_res_valid,
  output logic [ID_W-1:0]   o_res_id,
  output logic              o_err
);

  localparam int ENTRY_W = ID_W + 3*OPER_W;

  preState_t          preState, preNext;
  coreState_t         coreState, coreNext;
  logic [ID_W-1:0]    nextId, preId, coreId;
  logic [ENTRY_W-1:0] qHead;
  logic               qFull, qEmpty, push, pop;
  logic               muSeen, sigmaSeen;
  logic [CORE_N-1:0]  doneMask, maskNext;
  logic               launch, finish;

  assign o_opt_ready = ~qFull;
  assign push        = i_opt_valid & ~qFull;
  assign maskNext    = doneMask | i_core_done;

  mc_option_fifo #(.WIDTH(ENTRY_W), .DEPTH(QDEPTH), .LOG_DEPTH(LOG_QDEPTH)) optQueue (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pushData ({nextId, i_mu, i_s, i_sigma}),
    .pop      (pop),
    .popData  (qHead),
    .full     (qFull),
    .empty    (qEmpty)
  );

  // Option IDs are assigned at accept time and wrap naturally
  always_ff @(posedge clk) begin
    if (rst) nextId <= '0;
    else if (push) nextId <= nextId + ID_W'(1);
  end

  // Pre FSM next state: pop when idle, wait for both precompute dones, hold until cores take the bank
  always_comb begin
    preNext = preState;
    pop     = 1'b0;
    case (preState)
      PRE_IDLE: if (!qEmpty) begin
        pop     = 1'b1;
        preNext = PRE_RUN;
      end
      PRE_RUN:  if ((muSeen | i_mu_done) && (sigmaSeen | i_sigma_done)) preNext = PRE_HOLD;
      PRE_HOLD: if (launch) preNext = PRE_IDLE;
      default:  preNext = PRE_IDLE;
    endcase
  end

  // Pre FSM state, start pulse, operand registers and done latches
  always_ff @(posedge clk) begin
    if (rst) begin
      preState    <= PRE_IDLE;
      o_pre_start <= 1'b0;
      o_pre_mu    <= '0;
      o_pre_s     <= '0;
      o_pre_sigma <= '0;
      preId       <= '0;
      muSeen      <= 1'b0;
      sigmaSeen   <= 1'b0;
    end else begin
      preState    <= preNext;
      o_pre_start <= pop;
      if (pop) begin
        {preId, o_pre_mu, o_pre_s, o_pre_sigma} <= qHead;
        muSeen    <= 1'b0;
        sigmaSeen <= 1'b0;
      end else if (preState == PRE_RUN) begin
        muSeen    <= muSeen | i_mu_done;
        sigmaSeen <= sigmaSeen | i_sigma_done;
      end
    end
  end

  assign launch = (coreState == CORE_IDLE) && (preState == PRE_HOLD);
  assign finish = (coreState == CORE_RUN) && (&maskNext);

  // Core FSM next state: launch on a ready bank, finish when every core has reported
  always_comb begin
    coreNext = coreState;
    case (coreState)
      CORE_IDLE: if (preState == PRE_HOLD) coreNext = CORE_RUN;
      CORE_RUN:  if (&maskNext) coreNext = CORE_IDLE;
      default:   coreNext = CORE_IDLE;
    endcase
  end

  // Core FSM state, bank select, done mask and result reporting
  always_ff @(posedge clk) begin
    if (rst) begin
      coreState    <= CORE_IDLE;
      o_core_start <= 1'b0;
      o_switch     <= 1'b0;
      coreId       <= '0;
      doneMask     <= '0;
      o_res_valid  <= 1'b0;
      o_res_id     <= '0;
    end else begin
      coreState    <= coreNext;
      o_core_start <= launch;
      // Cores sample o_switch during the start cycle, so flip only after it
      if (o_core_start) o_switch <= ~o_switch;
      if (launch) begin
        coreId   <= preId;
        doneMask <= '0;
      end else if (coreState == CORE_RUN) begin
        doneMask <= maskNext;
      end
      o_res_valid <= finish;
      if (finish) o_res_id <= coreId;
    end
  end

  // Sticky error on any done pulse arriving while its owning FSM is not running
  always_ff @(posedge clk) begin
    if (rst) begin
      o_err <= 1'b0;
    end else if (((i_mu_done | i_sigma_done) && (preState != PRE_RUN)) ||
                 ((|i_core_done) && (coreState != CORE_RUN))) begin
      o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_option_scheduler.sv
// tb/tb_mc_option_scheduler.sv - directed self-checking bench for mc_option_scheduler
module tb_mc_option_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_opt_valid;
  logic        o_opt_ready;
  logic [17:0] i_mu, i_s, i_sigma;
  logic        o_pre_start;
  logic [17:0] o_pre_mu, o_pre_s, o_pre_sigma;
  logic        i_mu_done, i_sigma_done;
  logic        o_core_start;
  logic        o_switch;
  logic [1:0]  i_core_done;
  logic        o_res_valid;
  logic [3:0]  o_res_id;
  logic        o_err;

  int nVec = 0;
  int nMis = 0;
  int cyc  = 0;
  int base = 0;
  int preQ[$], coreQ[$], resQ[$], idQ[$];

  mc_option_scheduler dut (
    .clk(clk), .rst(rst),
    .i_opt_valid(i_opt_valid), .o_opt_ready(o_opt_ready),
    .i_mu(i_mu), .i_s(i_s), .i_sigma(i_sigma),
    .o_pre_start(o_pre_start), .o_pre_mu(o_pre_mu), .o_pre_s(o_pre_s), .o_pre_sigma(o_pre_sigma),
    .i_mu_done(i_mu_done), .i_sigma_done(i_sigma_done),
    .o_core_start(o_core_start), .o_switch(o_switch), .i_core_done(i_core_done),
    .o_res_valid(o_res_valid), .o_res_id(o_res_id), .o_err(o_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record event cycles relative to the current test's cycle 0
  always @(negedge clk) begin
    if (o_pre_start)  preQ.push_back(cyc - base);
    if (o_core_start) coreQ.push_back(cyc - base);
    if (o_res_valid) begin
      resQ.push_back(cyc - base);
      idQ.push_back(int'(o_res_id));
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nMis++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int qAt(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitTo(input int c);
    while (cyc - base < c) step();
  endtask

  task automatic clearQ();
    preQ.delete(); coreQ.delete(); resQ.delete(); idQ.delete();
  endtask

  task automatic idleInputs();
    i_opt_valid = 1'b0; i_mu = '0; i_s = '0; i_sigma = '0;
    i_mu_done = 1'b0; i_sigma_done = 1'b0; i_core_done = '0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    idleInputs();
    step(); step();
    rst = 1'b0;
    clearQ();
    base = cyc;
  endtask

  function automatic logic evNow(input int which);
    case (which)
      0:       return o_pre_start;
      1:       return o_core_start;
      default: return o_res_valid;
    endcase
  endfunction

  task automatic waitEv(input int which, input string tag);
    int n = 0;
    while (!evNow(which) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic offer(input logic [17:0] mu);
    i_opt_valid = 1'b1; i_mu = mu; i_s = 18'h04000; i_sigma = 18'h01000;
  endtask

  // Single option; sameCycle merges the done pulses but must not change timing
  task automatic runSingle(input bit sameCycle, input string t);
    doReset();
    i_opt_valid = 1'b1; i_mu = 18'h00800; i_s = 18'h04000; i_sigma = 18'h01000;
    step();
    idleInputs();
    waitTo(3);
    chk({t, "_pre_mu"}, o_pre_mu, 32'h00800);
    chk({t, "_pre_s"}, o_pre_s, 32'h04000);
    chk({t, "_pre_sigma"}, o_pre_sigma, 32'h01000);
    if (sameCycle) begin
      waitTo(12); i_mu_done = 1'b1; i_sigma_done = 1'b1; step(); idleInputs();
    end else begin
      waitTo(10); i_mu_done = 1'b1; step(); idleInputs();
      waitTo(12); i_sigma_done = 1'b1; step(); idleInputs();
    end
    waitTo(14);
    chk({t, "_sw_start"}, o_switch, 32'd0);
    waitTo(15);
    chk({t, "_sw_after"}, o_switch, 32'd1);
    if (sameCycle) begin
      waitTo(34); i_core_done = 2'b11; step(); idleInputs();
    end else begin
      waitTo(30); i_core_done = 2'b01; step(); idleInputs();
      waitTo(34); i_core_done = 2'b10; step(); idleInputs();
    end
    waitTo(38);
    chk({t, "_pre_cyc"}, qAt(preQ, 0), 32'd2);
    chk({t, "_core_cyc"}, qAt(coreQ, 0), 32'd14);
    chk({t, "_res_cyc"}, qAt(resQ, 0), 32'd35);
    chk({t, "_res_id"}, qAt(idQ, 0), 32'd0);
    chk({t, "_res_cnt"}, resQ.size(), 32'd1);
    chk({t, "_err"}, o_err, 32'd0);
  endtask

  initial begin
    int accepted;
    rst = 1'b1;
    idleInputs();
    doReset();
    chk("rst_ready", o_opt_ready, 32'd1);
    chk("rst_pre_start", o_pre_start, 32'd0);
    chk("rst_core_start", o_core_start, 32'd0);
    chk("rst_res_valid", o_res_valid, 32'd0);
    chk("rst_switch", o_switch, 32'd0);
    chk("rst_res_id", o_res_id, 32'd0);
    chk("rst_err", o_err, 32'd0);
    chk("rst_pre_mu", o_pre_mu, 32'd0);

    runSingle(1'b0, "single");
    runSingle(1'b1, "samecyc");

    // Queue fills while precompute is stalled on the first option
    doReset();
    offer(18'h00001); step(); idleInputs();
    waitEv(0, "qf_pre");
    accepted = 0;
    for (int i = 0; i < 5; i++) begin
      offer(18'h00100 + 18'(i));
      if (o_opt_ready) accepted++;
      if (i == 4) chk("qf_ready_low", o_opt_ready, 32'd0);
      step();
    end
    idleInputs();
    chk("qf_accepted", accepted, 32'd4);
    i_mu_done = 1'b1; i_sigma_done = 1'b1; step(); idleInputs();
    step();
    chk("qf_core_start", o_core_start, 32'd1);
    chk("qf_ready_still_low", o_opt_ready, 32'd0);
    step();
    chk("qf_ready_rise", o_opt_ready, 32'd1);
    chk("qf_pop_pre_start", o_pre_start, 32'd1);
    chk("qf_pop_mu", o_pre_mu, 32'h00100);

    // Two options overlapping precompute with core pricing
    doReset();
    offer(18'h00011); step();
    offer(18'h00022); step(); idleInputs();
    waitTo(5); i_mu_done = 1'b1; i_sigma_done = 1'b1; step(); idleInputs();
    waitTo(10);
    chk("two_sw_first", o_switch, 32'd1);
    i_mu_done = 1'b1; i_sigma_done = 1'b1; step(); idleInputs();
    waitTo(20); i_core_done = 2'b11; step(); idleInputs();
    waitTo(23);
    chk("two_sw_second", o_switch, 32'd0);
    waitTo(30); i_core_done = 2'b11; step(); idleInputs();
    waitTo(33);
    chk("two_pre0", qAt(preQ, 0), 32'd2);
    chk("two_pre1", qAt(preQ, 1), 32'd8);
    chk("two_core0", qAt(coreQ, 0), 32'd7);
    chk("two_core1", qAt(coreQ, 1), 32'd22);
    chk("two_res0", qAt(resQ, 0), 32'd21);
    chk("two_res1", qAt(resQ, 1), 32'd31);
    chk("two_id0", qAt(idQ, 0), 32'd0);
    chk("two_id1", qAt(idQ, 1), 32'd1);
    chk("two_err", o_err, 32'd0);

    // Error flag: stray dones set it, only reset clears it
    doReset();
    i_core_done = 2'b01; step(); idleInputs();
    chk("err_core_idle", o_err, 32'd1);
    step(); step(); step();
    chk("err_sticky", o_err, 32'd1);
    doReset();
    chk("err_cleared", o_err, 32'd0);
    i_mu_done = 1'b1; step(); idleInputs();
    chk("err_pre_idle", o_err, 32'd1);

    // Reset while cores run, precompute runs and the queue holds an option
    doReset();
    offer(18'h00031); step();
    offer(18'h00032); step();
    offer(18'h00033); step(); idleInputs();
    waitTo(5); i_mu_done = 1'b1; i_sigma_done = 1'b1; step(); idleInputs();
    waitTo(9);
    chk("mid_sw_set", o_switch, 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    clearQ();
    chk("mid_ready", o_opt_ready, 32'd1);
    chk("mid_switch", o_switch, 32'd0);
    chk("mid_pre_mu", o_pre_mu, 32'd0);
    chk("mid_pre_start", o_pre_start, 32'd0);
    chk("mid_core_start", o_core_start, 32'd0);
    chk("mid_res_valid", o_res_valid, 32'd0);
    chk("mid_err", o_err, 32'd0);
    step(); step(); step(); step();
    i_core_done = 2'b11; step(); idleInputs();
    step(); step();
    chk("mid_no_pop", preQ.size(), 32'd0);
    chk("mid_no_res", resQ.size(), 32'd0);
    chk("mid_stray_err", o_err, 32'd1);

    // ID wrap across 17 sequential options
    doReset();
    for (int k = 0; k < 17; k++) begin
      offer(18'(k)); step(); idleInputs();
      waitEv(0, "wrap_pre");
      i_mu_done = 1'b1; i_sigma_done = 1'b1; step(); idleInputs();
      waitEv(1, "wrap_core");
      i_core_done = 2'b11; step(); idleInputs();
      waitEv(2, "wrap_res");
      chk($sformatf("wrap_id%0d", k), o_res_id, 32'(k % 16));
      step();
    end
    chk("wrap_err", o_err, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
